// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
//   Bundles the ID-side inputs, the EX/MEM and MEM/WB forwarding taps and the
//   EX-side outputs of the ID/EX pipeline register.
//   master : driver of the ID/forwarding side, consumer of the EX side
//   slave  : the id_ex_stage itself
// ----------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
);
    logic              i_stall;
    logic              i_flush;
    logic              i_id_valid;
    logic [REG_AW-1:0] i_rs_addr;
    logic [REG_AW-1:0] i_rt_addr;
    logic [REG_AW-1:0] i_rd_addr;
    logic [DATA_W-1:0] i_rs_data;
    logic [DATA_W-1:0] i_rt_data;
    logic [DATA_W-1:0] i_imm;
    logic [CTRL_W-1:0] i_alu_control;
    logic              i_alu_src;
    logic              i_reg_write;
    logic              i_mem_read;
    logic              i_mem_write;
    logic              i_mem_to_reg;
    logic              i_exmem_reg_write;
    logic [REG_AW-1:0] i_exmem_rd;
    logic [DATA_W-1:0] i_exmem_result;
    logic              i_memwb_reg_write;
    logic [REG_AW-1:0] i_memwb_rd;
    logic [DATA_W-1:0] i_memwb_result;

    logic              o_ex_valid;
    logic [DATA_W-1:0] o_op1;
    logic [DATA_W-1:0] o_op2;
    logic [CTRL_W-1:0] o_alu_control;
    logic [DATA_W-1:0] o_store_data;
    logic [REG_AW-1:0] o_ex_rd;
    logic              o_ex_reg_write;
    logic              o_ex_mem_read;
    logic              o_ex_mem_write;
    logic              o_ex_mem_to_reg;
    logic              o_load_use_stall;

    modport slave (
        input  i_stall, i_flush, i_id_valid, i_rs_addr, i_rt_addr, i_rd_addr,
               i_rs_data, i_rt_data, i_imm, i_alu_control, i_alu_src,
               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
               i_exmem_reg_write, i_exmem_rd, i_exmem_result,
               i_memwb_reg_write, i_memwb_rd, i_memwb_result,
        output o_ex_valid, o_op1, o_op2, o_alu_control, o_store_data, o_ex_rd,
               o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_mem_to_reg,
               o_load_use_stall
    );

    modport master (
        output i_stall, i_flush, i_id_valid, i_rs_addr, i_rt_addr, i_rd_addr,
               i_rs_data, i_rt_data, i_imm, i_alu_control, i_alu_src,
               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
               i_exmem_reg_write, i_exmem_rd, i_exmem_result,
               i_memwb_reg_write, i_memwb_rd, i_memwb_result,
        input  o_ex_valid, o_op1, o_op2, o_alu_control, o_store_data, o_ex_rd,
               o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_mem_to_reg,
               o_load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the MIPS core, directly feeding the ALU.
//   Captures decoded operands/controls, resolves EX/MEM and MEM/WB forwarding,
//   selects the immediate for operand 2 and flags load-use hazards.
// Ports
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset, clears every register
//   bus      id_ex_stage_if.slave: ID inputs, forwarding taps, ALU-side outputs
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    id_ex_stage_if.slave   bus
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] alu_control;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } ex_t;

    ex_t               ex_q;
    ex_t               ex_d;
    logic              load_use;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // The load in EX cannot supply its data until MEM, so a dependent
    // instruction in ID must wait one cycle behind a bubble.
    assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & bus.i_id_valid &
                      ((ex_q.rd == bus.i_rs_addr) | (ex_q.rd == bus.i_rt_addr));

    // A bubble is the all-zero record: valid and every enable low.
    always_comb begin
        ex_d = ex_q;
        if (bus.i_flush) begin
            ex_d = '0;
        end else if (bus.i_stall) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d.valid       = bus.i_id_valid;
            ex_d.rs          = bus.i_rs_addr;
            ex_d.rt          = bus.i_rt_addr;
            ex_d.rd          = bus.i_rd_addr;
            ex_d.rs_data     = bus.i_rs_data;
            ex_d.rt_data     = bus.i_rt_data;
            ex_d.imm         = bus.i_imm;
            ex_d.alu_control = bus.i_alu_control;
            ex_d.alu_src     = bus.i_alu_src;
            ex_d.reg_write   = bus.i_reg_write;
            ex_d.mem_read    = bus.i_mem_read;
            ex_d.mem_write   = bus.i_mem_write;
            ex_d.mem_to_reg  = bus.i_mem_to_reg;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM is the younger producer and wins; $0 is hard-wired zero and
    // must never pick up a forwarded value.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (bus.i_exmem_reg_write && (bus.i_exmem_rd != '0) && (bus.i_exmem_rd == ex_q.rs)) begin
            fwd_rs = bus.i_exmem_result;
        end else if (bus.i_memwb_reg_write && (bus.i_memwb_rd != '0) && (bus.i_memwb_rd == ex_q.rs)) begin
            fwd_rs = bus.i_memwb_result;
        end
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (bus.i_exmem_reg_write && (bus.i_exmem_rd != '0) && (bus.i_exmem_rd == ex_q.rt)) begin
            fwd_rt = bus.i_exmem_result;
        end else if (bus.i_memwb_reg_write && (bus.i_memwb_rd != '0) && (bus.i_memwb_rd == ex_q.rt)) begin
            fwd_rt = bus.i_memwb_result;
        end
    end

    assign bus.o_ex_valid       = ex_q.valid;
    assign bus.o_op1            = fwd_rs;
    assign bus.o_op2            = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign bus.o_alu_control    = ex_q.alu_control;
    assign bus.o_store_data     = fwd_rt;
    assign bus.o_ex_rd          = ex_q.rd;
    assign bus.o_ex_reg_write   = ex_q.reg_write;
    assign bus.o_ex_mem_read    = ex_q.mem_read;
    assign bus.o_ex_mem_write   = ex_q.mem_write;
    assign bus.o_ex_mem_to_reg  = ex_q.mem_to_reg;
    assign bus.o_load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed scenarios plus a randomized run against a reference model that
//   tracks what instruction the EX stage should hold.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(4)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit        valid;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rsd, rtd, imm;
        bit [3:0]  ctrl;
        bit        src, rw, mr, mw, m2r;
    } ex_m_t;

    ex_m_t m;
    ex_m_t empty;

    function automatic bit m_lu();
        return m.valid && m.mr && (m.rd != 0) && (bus.i_id_valid === 1'b1) &&
               ((m.rd == bus.i_rs_addr) || (m.rd == bus.i_rt_addr));
    endfunction

    // Apply producers oldest first so the youngest matching one overwrites.
    function automatic bit [31:0] m_fwd(bit [4:0] a, bit [31:0] rf);
        bit [31:0] res;
        res = rf;
        if (a != 0 && bus.i_memwb_reg_write === 1'b1 && bus.i_memwb_rd == a) res = bus.i_memwb_result;
        if (a != 0 && bus.i_exmem_reg_write === 1'b1 && bus.i_exmem_rd == a) res = bus.i_exmem_result;
        return res;
    endfunction

    function automatic bit [31:0] m_op1();
        return m_fwd(m.rs, m.rsd);
    endfunction

    function automatic bit [31:0] m_store();
        return m_fwd(m.rt, m.rtd);
    endfunction

    function automatic bit [31:0] m_op2();
        return m.src ? m.imm : m_fwd(m.rt, m.rtd);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= empty;
        end else if (bus.i_flush) begin
            m <= empty;
        end else if (!bus.i_stall) begin
            if (m_lu()) begin
                m <= empty;
            end else begin
                m.valid <= bus.i_id_valid;
                m.rs    <= bus.i_rs_addr;
                m.rt    <= bus.i_rt_addr;
                m.rd    <= bus.i_rd_addr;
                m.rsd   <= bus.i_rs_data;
                m.rtd   <= bus.i_rt_data;
                m.imm   <= bus.i_imm;
                m.ctrl  <= bus.i_alu_control;
                m.src   <= bus.i_alu_src;
                m.rw    <= bus.i_reg_write;
                m.mr    <= bus.i_mem_read;
                m.mw    <= bus.i_mem_write;
                m.m2r   <= bus.i_mem_to_reg;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.i_stall = 0; bus.i_flush = 0; bus.i_id_valid = 0;
        bus.i_rs_addr = 0; bus.i_rt_addr = 0; bus.i_rd_addr = 0;
        bus.i_rs_data = 0; bus.i_rt_data = 0; bus.i_imm = 0;
        bus.i_alu_control = 0; bus.i_alu_src = 0; bus.i_reg_write = 0;
        bus.i_mem_read = 0; bus.i_mem_write = 0; bus.i_mem_to_reg = 0;
        bus.i_exmem_reg_write = 0; bus.i_exmem_rd = 0; bus.i_exmem_result = 0;
        bus.i_memwb_reg_write = 0; bus.i_memwb_rd = 0; bus.i_memwb_result = 0;
    endtask

    task automatic drive_id(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                            input bit [31:0] rsd, input bit [31:0] rtd, input bit [31:0] imm,
                            input bit [3:0] ctrl, input bit src, input bit mr);
        bus.i_id_valid = 1; bus.i_rs_addr = rs; bus.i_rt_addr = rt; bus.i_rd_addr = rd;
        bus.i_rs_data = rsd; bus.i_rt_data = rtd; bus.i_imm = imm;
        bus.i_alu_control = ctrl; bus.i_alu_src = src; bus.i_reg_write = 1;
        bus.i_mem_read = mr; bus.i_mem_write = 0; bus.i_mem_to_reg = mr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if ({bus.o_ex_valid, bus.o_ex_reg_write, bus.o_ex_mem_read, bus.o_ex_mem_write,
             bus.o_ex_mem_to_reg, bus.o_load_use_stall} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000",
                {bus.o_ex_valid, bus.o_ex_reg_write, bus.o_ex_mem_read, bus.o_ex_mem_write,
                 bus.o_ex_mem_to_reg, bus.o_load_use_stall});
        end
        vectors++;
        if ({bus.o_op1, bus.o_op2, bus.o_store_data, bus.o_alu_control, bus.o_ex_rd} !== '0) begin
            errors++; $display("FAIL reset_data: op1=%h op2=%h sd=%h ctrl=%h rd=%h want all 0",
                bus.o_op1, bus.o_op2, bus.o_store_data, bus.o_alu_control, bus.o_ex_rd);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_capture();
        idle();
        step();
        drive_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 4'b0010, 1'b0, 1'b0);
        step();
        idle();
        #1;
        vectors++;
        if (bus.o_op1 !== 32'd5) begin errors++; $display("FAIL capture_op1: got %h want 5", bus.o_op1); end
        vectors++;
        if (bus.o_op2 !== 32'd7) begin errors++; $display("FAIL capture_op2: got %h want 7", bus.o_op2); end
        vectors++;
        if (bus.o_alu_control !== 4'b0010 || bus.o_ex_valid !== 1'b1 || bus.o_ex_rd !== 5'd3) begin
            errors++; $display("FAIL capture_ctrl: ctrl=%b valid=%b rd=%0d want 0010 1 3",
                bus.o_alu_control, bus.o_ex_valid, bus.o_ex_rd);
        end
    endtask

    task automatic test_forward();
        idle();
        drive_id(5'd3, 5'd6, 5'd9, 32'h11, 32'h66, 32'd0, 4'b0010, 1'b0, 1'b0);
        step();
        idle();
        bus.i_exmem_reg_write = 1; bus.i_exmem_rd = 5'd3; bus.i_exmem_result = 32'hAA;
        bus.i_memwb_reg_write = 1; bus.i_memwb_rd = 5'd3; bus.i_memwb_result = 32'hBB;
        #1;
        vectors++;
        if (bus.o_op1 !== 32'hAA) begin errors++; $display("FAIL fwd_exmem: got %h want aa", bus.o_op1); end
        bus.i_exmem_reg_write = 0;
        #1;
        vectors++;
        if (bus.o_op1 !== 32'hBB) begin errors++; $display("FAIL fwd_memwb: got %h want bb", bus.o_op1); end
        bus.i_exmem_reg_write = 1; bus.i_exmem_rd = 5'd0; bus.i_memwb_rd = 5'd0;
        #1;
        vectors++;
        if (bus.o_op1 !== 32'h11) begin errors++; $display("FAIL fwd_r0: got %h want 11", bus.o_op1); end
        bus.i_memwb_rd = 5'd6;
        #1;
        vectors++;
        if (bus.o_op2 !== 32'hBB || bus.o_store_data !== 32'hBB) begin
            errors++; $display("FAIL fwd_rt: op2=%h sd=%h want bb bb", bus.o_op2, bus.o_store_data);
        end
    endtask

    task automatic test_load_use();
        idle();
        drive_id(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 32'h10, 4'b0010, 1'b1, 1'b1);
        step();
        drive_id(5'd4, 5'd5, 5'd7, 32'h44, 32'h55, 32'h0, 4'b0010, 1'b0, 1'b0);
        #1;
        vectors++;
        if (bus.o_load_use_stall !== 1'b1) begin
            errors++; $display("FAIL lu_detect: got %b want 1", bus.o_load_use_stall);
        end
        step();
        vectors++;
        if (bus.o_ex_valid !== 1'b0 || bus.o_ex_mem_read !== 1'b0 || bus.o_load_use_stall !== 1'b0) begin
            errors++; $display("FAIL lu_bubble: valid=%b mr=%b lu=%b want 0 0 0",
                bus.o_ex_valid, bus.o_ex_mem_read, bus.o_load_use_stall);
        end
        step();
        vectors++;
        if (bus.o_ex_valid !== 1'b1 || bus.o_op1 !== 32'h44 || bus.o_ex_rd !== 5'd7) begin
            errors++; $display("FAIL lu_resume: valid=%b op1=%h rd=%0d want 1 44 7",
                bus.o_ex_valid, bus.o_op1, bus.o_ex_rd);
        end
        // A load targeting $0 never creates a hazard.
        drive_id(5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b1);
        step();
        drive_id(5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0);
        #1;
        vectors++;
        if (bus.o_load_use_stall !== 1'b0) begin
            errors++; $display("FAIL lu_r0: got %b want 0", bus.o_load_use_stall);
        end
    endtask

    task automatic test_stall_flush();
        idle();
        drive_id(5'd2, 5'd3, 5'd4, 32'h123, 32'h456, 32'h0, 4'b0110, 1'b0, 1'b0);
        step();
        bus.i_stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_id(5'd9, 5'd10, 5'd11, $urandom, $urandom, $urandom, 4'b0001, 1'b1, 1'b0);
            step();
            vectors++;
            if (bus.o_op1 !== 32'h123 || bus.o_alu_control !== 4'b0110 || bus.o_ex_valid !== 1'b1 ||
                bus.o_ex_rd !== 5'd4) begin
                errors++; $display("FAIL stall_hold%0d: op1=%h ctrl=%b valid=%b rd=%0d want 123 0110 1 4",
                    i, bus.o_op1, bus.o_alu_control, bus.o_ex_valid, bus.o_ex_rd);
            end
        end
        bus.i_flush = 1;
        step();
        vectors++;
        if (bus.o_ex_valid !== 1'b0 || bus.o_ex_reg_write !== 1'b0 || bus.o_op1 !== 32'h0) begin
            errors++; $display("FAIL stall_flush: valid=%b rw=%b op1=%h want 0 0 0",
                bus.o_ex_valid, bus.o_ex_reg_write, bus.o_op1);
        end
        idle();
    endtask

    task automatic test_immediate();
        idle();
        drive_id(5'd1, 5'd2, 5'd3, 32'h1, 32'h77, 32'hFFFF_FFFC, 4'b0111, 1'b1, 1'b0);
        step();
        idle();
        bus.i_memwb_reg_write = 1; bus.i_memwb_rd = 5'd2; bus.i_memwb_result = 32'h99;
        #1;
        vectors++;
        if (bus.o_op2 !== 32'hFFFF_FFFC || bus.o_alu_control !== 4'b0111) begin
            errors++; $display("FAIL imm_op2: op2=%h ctrl=%b want fffffffc 0111", bus.o_op2, bus.o_alu_control);
        end
        vectors++;
        if (bus.o_store_data !== 32'h99) begin
            errors++; $display("FAIL imm_store: got %h want 99", bus.o_store_data);
        end
    endtask

    task automatic test_reset_midstream();
        idle();
        drive_id(5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 4'b0010, 1'b0, 1'b0);
        step();
        idle();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.o_ex_valid, bus.o_ex_reg_write, bus.o_alu_control, bus.o_ex_rd, bus.o_op1, bus.o_op2} !== '0) begin
            errors++; $display("FAIL reset_mid: valid=%b rw=%b ctrl=%b rd=%0d op1=%h op2=%h want all 0",
                bus.o_ex_valid, bus.o_ex_reg_write, bus.o_alu_control, bus.o_ex_rd, bus.o_op1, bus.o_op2);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit [3:0] codes [6];
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        idle();
        step();
        for (int n = 0; n < 400; n++) begin
            bus.i_stall           = ($urandom_range(0, 7) == 0);
            bus.i_flush           = ($urandom_range(0, 15) == 0);
            bus.i_id_valid        = ($urandom_range(0, 4) != 0);
            bus.i_rs_addr         = 5'($urandom_range(0, 7));
            bus.i_rt_addr         = 5'($urandom_range(0, 7));
            bus.i_rd_addr         = 5'($urandom_range(0, 7));
            bus.i_rs_data         = $urandom;
            bus.i_rt_data         = $urandom;
            bus.i_imm             = $urandom;
            bus.i_alu_control     = codes[$urandom_range(0, 5)];
            bus.i_alu_src         = 1'($urandom);
            bus.i_reg_write       = 1'($urandom);
            bus.i_mem_read        = ($urandom_range(0, 2) == 0);
            bus.i_mem_write       = 1'($urandom);
            bus.i_mem_to_reg      = 1'($urandom);
            bus.i_exmem_reg_write = 1'($urandom);
            bus.i_exmem_rd        = 5'($urandom_range(0, 7));
            bus.i_exmem_result    = $urandom;
            bus.i_memwb_reg_write = 1'($urandom);
            bus.i_memwb_rd        = 5'($urandom_range(0, 7));
            bus.i_memwb_result    = $urandom;
            #2;
            vectors++;
            if (bus.o_load_use_stall !== m_lu()) begin
                errors++; $display("FAIL rnd_lu[%0d]: got %b want %b", n, bus.o_load_use_stall, m_lu());
            end
            vectors++;
            if (bus.o_op1 !== m_op1() || bus.o_op2 !== m_op2() || bus.o_store_data !== m_store()) begin
                errors++; $display("FAIL rnd_ops[%0d]: op1=%h op2=%h sd=%h want %h %h %h", n,
                    bus.o_op1, bus.o_op2, bus.o_store_data, m_op1(), m_op2(), m_store());
            end
            vectors++;
            if ({bus.o_ex_valid, bus.o_alu_control, bus.o_ex_rd, bus.o_ex_reg_write, bus.o_ex_mem_read,
                 bus.o_ex_mem_write, bus.o_ex_mem_to_reg} !==
                {m.valid, m.ctrl, m.rd, m.rw, m.mr, m.mw, m.m2r}) begin
                errors++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", n,
                    {bus.o_ex_valid, bus.o_alu_control, bus.o_ex_rd, bus.o_ex_reg_write, bus.o_ex_mem_read,
                     bus.o_ex_mem_write, bus.o_ex_mem_to_reg},
                    {m.valid, m.ctrl, m.rd, m.rw, m.mr, m.mw, m.m2r});
            end
            step();
        end
        idle();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_capture();
        test_forward();
        test_load_use();
        test_stall_flush();
        test_immediate();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
